// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSN   = 32'h0000_0000;
    localparam logic [31:0] INSN_BYTES = 32'd4;
    localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + INSN_BYTES;
    endfunction

endpackage

// File: rtl/if_fetch_hold_buf.sv
// One-entry {pc_4, insn} buffer that keeps a fetched instruction alive while ID stalls.
module if_fetch_hold_buf
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] capture_pc_4,
    input  logic [31:0] capture_insn,
    output logic [31:0] held_pc_4,
    output logic [31:0] held_insn
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            held_pc_4 <= 32'h0;
            held_insn <= NOP_INSN;
        end else if (load) begin
            held_pc_4 <= capture_pc_4;
            held_insn <= capture_insn;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem read in flight.
// Define IF_FETCH_PERF_EN to add the perf_stall_cycles / perf_redirects counters.
//
//  state | meaning
//  REQ   | issue a read at pc
//  WAIT  | read accepted, data pending
//  HOLD  | instruction captured in the hold buffer while ID stalls
//  DRAIN | stale response still owed after a redirect; discard it
module if_fetch_unit
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_shouldStall,
    input  logic        ex_shouldJumpOrBranch,
    input  logic [31:0] ex_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc_4,
    output logic [31:0] if_instruction
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_redirects
`endif
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_plus_4;
    logic         redirect;
    logic         stall;
    logic         hold_load;
    logic         hold_clear;
    logic [31:0]  held_pc_4;
    logic [31:0]  held_insn;

    assign pc_plus_4 = seq_pc(pc);
    assign redirect  = ex_shouldJumpOrBranch;
    assign stall     = id_shouldStall;

    assign hold_load  = !redirect && (state == WAIT) && imem_rvalid && stall;
    assign hold_clear = redirect || ((state == HOLD) && !stall);

    if_fetch_hold_buf u_hold_buf (
        .clk          (clk),
        .rst          (rst),
        .load         (hold_load),
        .clear        (hold_clear),
        .capture_pc_4 (pc_plus_4),
        .capture_insn (imem_rdata),
        .held_pc_4    (held_pc_4),
        .held_insn    (held_insn)
    );

    // Output mux: pass-through in WAIT, hold buffer in HOLD, bubble otherwise.
    always_comb begin
        imem_req       = 1'b0;
        imem_addr      = 32'h0;
        if_valid       = 1'b0;
        if_pc_4        = 32'h0;
        if_instruction = NOP_INSN;
        if (!rst && !redirect) begin
            case (state)
                REQ: begin
                    imem_req  = 1'b1;
                    imem_addr = pc;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if_valid       = 1'b1;
                        if_pc_4        = pc_plus_4;
                        if_instruction = imem_rdata;
                        if (!stall) begin
                            imem_req  = 1'b1;
                            imem_addr = pc_plus_4;
                        end
                    end
                end
                HOLD: begin
                    if_valid       = 1'b1;
                    if_pc_4        = held_pc_4;
                    if_instruction = held_insn;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ;
            pc    <= RESET_PC;
        end else if (redirect) begin
            pc <= ex_target & WORD_MASK;
            case (state)
                WAIT:    state <= imem_rvalid ? REQ : DRAIN;
                // A stale response landing in this very cycle is already drained.
                DRAIN:   state <= imem_rvalid ? REQ : DRAIN;
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (imem_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (!stall) begin
                            pc    <= pc_plus_4;
                            state <= imem_ready ? WAIT : REQ;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc    <= pc_plus_4;
                        state <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= 32'h0;
            perf_redirects    <= 32'h0;
        end else begin
            if (if_valid && stall) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (redirect) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: expected {pc_4, insn} queued per scenario, popped on consumption.
module tb_if_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] pc_4;
        logic [31:0] insn;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = 32'h0;
    logic        ready = 1'b1;
    int          lat = 1;
    logic        sb_en = 1'b0;

    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] pc_4;
    logic [31:0] insn;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_pc_4;
    logic [31:0] w_insn;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t e;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_stall, perf_redir, w_perf_stall, w_perf_redir;
`endif

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .id_shouldStall        (stall),
        .ex_shouldJumpOrBranch (redirect),
        .ex_target             (target),
        .imem_req              (req),
        .imem_addr             (addr),
        .imem_ready            (ready),
        .imem_rvalid           (rvalid),
        .imem_rdata            (rdata),
        .if_valid              (valid),
        .if_pc_4               (pc_4),
        .if_instruction        (insn)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_stall_cycles     (perf_stall),
        .perf_redirects        (perf_redir)
`endif
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk                   (clk),
        .rst                   (rst),
        .id_shouldStall        (1'b0),
        .ex_shouldJumpOrBranch (1'b0),
        .ex_target             (32'h0),
        .imem_req              (w_req),
        .imem_addr             (w_addr),
        .imem_ready            (1'b1),
        .imem_rvalid           (w_rvalid),
        .imem_rdata            (w_rdata),
        .if_valid              (w_valid),
        .if_pc_4               (w_pc_4),
        .if_instruction        (w_insn)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_stall_cycles     (w_perf_stall),
        .perf_redirects        (w_perf_redir)
`endif
    );

    // Memory model: data = addr ^ K, latency lat cycles after acceptance.
    int          cnt;
    logic [31:0] paddr;
    always @(posedge clk) begin
        if (rst) begin
            cnt    <= 0;
            rvalid <= 1'b0;
            rdata  <= 32'h0;
        end else begin
            rvalid <= 1'b0;
            if (cnt == 1) begin
                rvalid <= 1'b1;
                rdata  <= paddr ^ K;
            end
            if (cnt > 0) cnt <= cnt - 1;
            if (req && ready) begin
                if (lat <= 1) begin
                    rvalid <= 1'b1;
                    rdata  <= addr ^ K;
                end else begin
                    cnt   <= lat - 1;
                    paddr <= addr;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            w_rvalid <= 1'b0;
            w_rdata  <= 32'h0;
        end else begin
            w_rvalid <= w_req;
            w_rdata  <= w_addr ^ K;
        end
    end

    // Scoreboard: every consumed instruction must be the next expected one.
    always @(negedge clk) begin
        if (sb_en) begin
            if (valid && !stall && !redirect) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc_4=%h insn=%h, nothing expected", pc_4, insn);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_4 !== e.pc_4 || insn !== e.insn) begin
                        n_fail++;
                        $display("FAIL sb_order: got pc_4=%h insn=%h, want pc_4=%h insn=%h",
                                 pc_4, insn, e.pc_4, e.insn);
                    end
                end
            end else if (!valid) begin
                n_tests++;
                if (pc_4 !== 32'h0 || insn !== 32'h0) begin
                    n_fail++;
                    $display("FAIL bubble: got pc_4=%h insn=%h, want 0/0", pc_4, insn);
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] a);
        exp_t t;
        t.pc_4 = a + 32'd4;
        t.insn = a ^ K;
        exp_q.push_back(t);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_tests++;
        if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", req); end
        n_tests++;
        if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr); end
        n_tests++;
        if (pc_4 !== 32'h0 || insn !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs: got pc_4=%h insn=%h want 0/0", pc_4, insn);
        end
        n_tests++;
        if (w_req !== 1'b0) begin n_fail++; $display("FAIL reset_wrap_req: got %b want 0", w_req); end
    endtask

    task automatic test_wrap_pc();
        logic [31:0] seen_addr[2];
        int          na = 0;
        logic        seen = 1'b0;
        logic [31:0] f_pc4 = 32'hDEAD_BEEF;
        logic [31:0] f_insn = 32'hDEAD_BEEF;
        stall = 1'b1;
        sb_en = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (w_req && na < 2) begin seen_addr[na] = w_addr; na++; end
            if (w_valid && !seen) begin seen = 1'b1; f_pc4 = w_pc_4; f_insn = w_insn; end
        end
        n_tests++;
        if (na !== 2) begin
            n_fail++; $display("FAIL wrap_req_count: got %0d want 2", na);
        end else begin
            n_tests++;
            if (seen_addr[0] !== 32'hFFFF_FFFC) begin
                n_fail++; $display("FAIL wrap_first_addr: got %h want fffffffc", seen_addr[0]);
            end
            n_tests++;
            if (seen_addr[1] !== 32'h0) begin
                n_fail++; $display("FAIL wrap_second_addr: got %h want 0", seen_addr[1]);
            end
        end
        n_tests++;
        if (!seen || f_pc4 !== 32'h0 || f_insn !== (32'hFFFF_FFFC ^ K)) begin
            n_fail++;
            $display("FAIL wrap_first_insn: got seen=%b pc_4=%h insn=%h want pc_4=0 insn=%h",
                     seen, f_pc4, f_insn, 32'hFFFF_FFFC ^ K);
        end
    endtask

    // Starts from HOLD, releases the stall and re-stalls once the queue drains.
    task automatic test_stream(input logic [31:0] first, input int n, input int exp_cycles);
        int used = -1;
        for (int i = 0; i < n; i++) push_exp(first + 32'(4 * i));
        @(posedge clk); #2;
        stall = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0) begin
                stall = 1'b1;
                used = i + 1;
                break;
            end
        end
        n_tests++;
        if (used !== exp_cycles) begin
            n_fail++; $display("FAIL stream_cycles: got %0d want %0d", used, exp_cycles);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (valid !== 1'b1 || pc_4 !== 32'd12 || insn !== (32'd8 ^ K) || req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got valid=%b pc_4=%h insn=%h req=%b want 1/0000000c/%h/0",
                         i, valid, pc_4, insn, req, 32'd8 ^ K);
            end
        end
        push_exp(32'd8);
        @(posedge clk); #2;
        stall = 1'b0;
        @(posedge clk); #2;
        stall = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req !== 1'b1 || addr !== 32'd12) begin
            n_fail++; $display("FAIL stall_next_addr: got req=%b addr=%h want 1/0000000c", req, addr);
        end
        @(posedge clk); #2;
    endtask

    task automatic test_redirect_drain();
        logic done = 1'b0;
        lat = 2;
        push_exp(32'd36);
        @(posedge clk); #2;
        stall = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        redirect = 1'b1;
        target = 32'h0000_0103;
        @(negedge clk);
        n_tests++;
        if (valid !== 1'b0 || insn !== 32'h0 || req !== 1'b0) begin
            n_fail++; $display("FAIL redir_cycle: got valid=%b insn=%h req=%b want 0/0/0", valid, insn, req);
        end
        @(posedge clk); #2;
        redirect = 1'b0;
        lat = 1;
        push_exp(32'h100);
        @(negedge clk);
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_stale: got valid=%b insn=%h want valid 0", valid, insn);
        end
        @(posedge clk); #2;
        @(negedge clk);
        n_tests++;
        if (req !== 1'b1 || addr !== 32'h100) begin
            n_fail++; $display("FAIL redir_addr: got req=%b addr=%h want 1/00000100", req, addr);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0) begin stall = 1'b1; done = 1'b1; break; end
        end
        n_tests++;
        if (!done) begin n_fail++; $display("FAIL redir_timeout: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_redirect_in_hold();
        logic done = 1'b0;
        @(posedge clk); #2;
        redirect = 1'b1;
        target = 32'h0000_0200;
        @(negedge clk);
        n_tests++;
        if (insn !== 32'h0 || valid !== 1'b0 || req !== 1'b0) begin
            n_fail++; $display("FAIL hold_redir: got insn=%h valid=%b req=%b want 0/0/0", insn, valid, req);
        end
        @(posedge clk); #2;
        redirect = 1'b0;
        stall = 1'b0;
        push_exp(32'h200);
        @(negedge clk);
        n_tests++;
        if (req !== 1'b1 || addr !== 32'h200) begin
            n_fail++; $display("FAIL hold_redir_addr: got req=%b addr=%h want 1/00000200", req, addr);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0) begin stall = 1'b1; done = 1'b1; break; end
        end
        n_tests++;
        if (!done) begin n_fail++; $display("FAIL hold_redir_timeout: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_ready_low_reset();
        logic done = 1'b0;
        ready = 1'b0;
        push_exp(32'h204);
        @(posedge clk); #2;
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            @(negedge clk);
            n_tests++;
            if (req !== 1'b1 || addr !== 32'h208 || valid !== 1'b0) begin
                n_fail++; $display("FAIL ready_low[%0d]: got req=%b addr=%h valid=%b want 1/00000208/0",
                                   i, req, addr, valid);
            end
        end
        @(posedge clk); #2;
        ready = 1'b1;
        lat = 2;
        @(posedge clk); #2;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (valid !== 1'b0 || req !== 1'b0 || addr !== 32'h0 || pc_4 !== 32'h0 || insn !== 32'h0) begin
                n_fail++; $display("FAIL mid_rst[%0d]: got valid=%b req=%b addr=%h pc_4=%h insn=%h want all 0",
                                   i, valid, req, addr, pc_4, insn);
            end
            @(posedge clk); #2;
        end
        rst = 1'b0;
        lat = 1;
        push_exp(32'd0);
        push_exp(32'd4);
        push_exp(32'd8);
        @(negedge clk);
        n_tests++;
        if (req !== 1'b1 || addr !== 32'h0) begin
            n_fail++; $display("FAIL refetch_addr: got req=%b addr=%h want 1/00000000", req, addr);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0) begin stall = 1'b1; done = 1'b1; break; end
        end
        n_tests++;
        if (!done) begin n_fail++; $display("FAIL refetch_timeout: got %0d pending want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_wrap_pc();
        test_stream(32'd0, 2, 3);
        test_stall();
        test_stream(32'd12, 6, 7);
        test_redirect_drain();
        test_redirect_in_hold();
        test_ready_low_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL leftover: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
